epochtv1_bus_master: RTL and testbench
======================================

Name: epochtv1_bus_master

Overview:
- CPU-side bus initiator for the Epoch TV-1 host port; drives A/DB/RDB/WRB/CSB exactly as the uPD7801 external bus would.
- Used by the save-state / debug loader to read and write VRAM, BGM, OAM and registers without the CPU core.
- Accepts single or burst requests over a valid/ready handshake and sequences setup/strobe/hold phases on the pixel clock enable.
- Returns one read-data beat per read access.

Parameters:
- SETUP_CYC, 1, CE ticks with address valid, CSB low and strobes high before the strobe (range 1-3).
- STROBE_CYC, 2, CE ticks with RDB or WRB low (range 2-7).
- HOLD_CYC, 1, CE ticks after the strobe with CSB low and strobes high (range 1-3).

Ports:
- CLK  in  1  clock (XTAL * 2)
- RESB  in  1  asynchronous active-low reset
- CE  in  1  pixel clock enable; all phase timing counts CE ticks
- REQ_VALID  in  1  request offered
- REQ_READY  out  1  high in IDLE only
- REQ_WRITE  in  1  1 = write burst, 0 = read burst
- REQ_ADDR  in  13  first TV-1 address
- REQ_WDATA  in  8  write data, repeated on every beat (fill)
- REQ_LEN  in  9  beat count; 0 is treated as 1
- REQ_INC  in  1  1 = post-increment address per beat, 0 = fixed address
- RSP_VALID  out  1  one-CLK pulse per completed read beat
- RSP_RDATA  out  8  captured read byte, held until the next capture
- BUSY  out  1  high from request accept until the final HOLD completes
- A  out  13  bus address
- DB_I  in  8  data from TV-1 (its DB_O)
- DB_O  out  8  data to TV-1
- DB_OE  out  1  master drives DB
- RDB  out  1  active-low read strobe
- WRB  out  1  active-low write strobe
- CSB  out  1  active-low chip select

Behaviour:
- Reset is asynchronous and active-low.
  - During RESB low: state IDLE; CSB=RDB=WRB=1; A=0; DB_O=0; DB_OE=0; RSP_VALID=0; RSP_RDATA=0; BUSY=0; REQ_READY=0.
  - REQ_READY rises on the first CLK after RESB deasserts.
  - Reset mid-burst abandons the burst and returns all strobes high immediately. No partial-beat completion.
- States: IDLE, SETUP, STROBE, HOLD. A per-phase tick counter reloads on each state entry.
- IDLE:
  - REQ_READY=1.
  - On a CLK where REQ_VALID & REQ_READY, latch write/addr/wdata/inc and a 9-bit beat counter (max(REQ_LEN,1)).
  - Set A=REQ_ADDR, CSB=0, BUSY=1. DB_OE=1 and DB_O=wdata if write. Go to SETUP.
  - Acceptance does not need CE.
- SETUP: strobes high. After SETUP_CYC CE ticks go to STROBE and drive RDB=0 (read) or WRB=0 (write).
- STROBE:
  - Held for STROBE_CYC CE ticks.
  - Read: on the CE edge ending the last tick, RSP_RDATA<=DB_I and RSP_VALID pulses for that single CLK.
  - Exiting STROBE raises the strobe and enters HOLD.
- HOLD: CSB, A and DB_O unchanged. After HOLD_CYC CE ticks, decrement the beat counter.
  - Counter reaches 0: CSB=1, DB_OE=0, BUSY=0, go to IDLE. REQ_READY is 1 on the next CLK.
  - Otherwise: A<=A+1 if inc (13-bit wrap, 1FFF->0000), CSB stays low, go to SETUP.
- Strobe ordering:
  - RDB and WRB are never low together.
  - A and DB_O change only while both strobes are high.
  - CSB never toggles while a strobe is low.
- CE low: state and counters are frozen, outputs are held. REQ_VALID/REQ_READY acceptance in IDLE is unaffected.
- Per-beat cost is SETUP_CYC+STROBE_CYC+HOLD_CYC CE ticks. With defaults, a 1-beat access occupies 4 CE ticks after acceptance.
- REQ_* inputs are ignored while BUSY.

Test Plan:
- Single write: addr 0x1005, wdata 0xA5, len 1 -> A=0x1005 and DB_O=0xA5 with DB_OE=1 for 4 CE ticks; WRB low exactly CE ticks 2-3; CSB low ticks 1-4; TV-1 BGM[5] reads back 0xA5; REQ_READY returns.
- Single read: preload OAM byte 0x1203=0x3C, read addr 0x1203 -> one RSP_VALID pulse with RSP_RDATA=0x3C; DB_OE never asserted; RDB low 2 CE ticks.
- Fill burst: write addr 0x0000, wdata 0x00, len 256, inc=1 -> VRAM bytes 0x000-0x0FF cleared; 256 WRB pulses; CSB continuously low; BUSY low after 1024 CE ticks.
- Wrap and fixed address: read addr 0x1FFF, len 2, inc=1 -> second beat at A=0x0000. Write addr 0x1400, len 3, inc=0 -> A stays 0x1400, 3 WRB pulses.
- CE gating: CE asserted 1 in 3 CLKs during a read -> identical phase counts in CE ticks; RSP_VALID still exactly 1 CLK wide.
- Reset mid-burst: assert RESB low during a STROBE of beat 2 of 4 -> CSB/RDB/WRB high and DB_OE low without a CLK edge; after release, IDLE with REQ_READY=1 and no further RSP_VALID.

Source files
------------

// File: rtl/epochtv1_bus_master_if.sv
// Bus bundle between the request side, the Epoch TV-1 host port and
// epochtv1_bus_master.
//   REQ_*  : request handshake (valid/ready), burst descriptor
//   RSP_*  : read-data return, one pulse per read beat
//   BUSY   : master owns the bus
//   A, DB_I, DB_O, DB_OE, RDB, WRB, CSB : uPD7801-style external bus
// master modport: the bus master's view.
// slave modport: the view of whatever surrounds it (requester plus TV-1).
interface epochtv1_bus_master_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [12:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic [8:0]  REQ_LEN;
  logic        REQ_INC;
  logic        RSP_VALID;
  logic [7:0]  RSP_RDATA;
  logic        BUSY;
  logic [12:0] A;
  logic [7:0]  DB_I;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic        RDB;
  logic        WRB;
  logic        CSB;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_LEN, REQ_INC, DB_I,
    output REQ_READY, RSP_VALID, RSP_RDATA, BUSY, A, DB_O, DB_OE, RDB, WRB, CSB
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, REQ_LEN, REQ_INC, DB_I,
    input  REQ_READY, RSP_VALID, RSP_RDATA, BUSY, A, DB_O, DB_OE, RDB, WRB, CSB
  );
endinterface

// File: rtl/epochtv1_bus_master.sv
// Host-port bus initiator for the Epoch TV-1. Takes single or burst
// read/write requests and sequences SETUP / STROBE / HOLD phases, each
// timed in CE ticks, on the A/DB/RDB/WRB/CSB bus.
// Ports:
//   CLK  : clock (XTAL * 2)
//   RESB : asynchronous active-low reset
//   CE   : pixel clock enable; every phase length counts CE ticks
//   bus  : request/response handshake and TV-1 bus (master modport)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | REQ_READY high, waiting for a request; CSB high
// SETUP  | address (and write data) valid, CSB low, strobes high
// STROBE | RDB or WRB low; read data captured on the last tick
// HOLD   | strobes high, CSB/A/DB_O held; then next beat or IDLE
module epochtv1_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic CLK,
  input  logic RESB,
  input  logic CE,
  epochtv1_bus_master_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  localparam logic [2:0] SETUP_LD  = 3'(SETUP_CYC);
  localparam logic [2:0] STROBE_LD = 3'(STROBE_CYC);
  localparam logic [2:0] HOLD_LD   = 3'(HOLD_CYC);

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [8:0]  beats_q, beats_d;
  logic        write_q, write_d;
  logic        inc_q, inc_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  db_o_q, db_o_d;
  logic        db_oe_q, db_oe_d;
  logic        csb_q, csb_d;
  logic        rdb_q, rdb_d;
  logic        wrb_q, wrb_d;
  logic        busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        ready_en_q, ready_en_d;
  logic        req_ready;

  // ready_en_q keeps REQ_READY low until the first clock after reset release
  assign req_ready = (state_q == S_IDLE) && ready_en_q;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    beats_d     = beats_q;
    write_d     = write_q;
    inc_d       = inc_q;
    addr_d      = addr_q;
    db_o_d      = db_o_q;
    db_oe_d     = db_oe_q;
    csb_d       = csb_q;
    rdb_d       = rdb_q;
    wrb_d       = wrb_q;
    busy_d      = busy_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ready_en_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        // acceptance is independent of CE
        if (bus.REQ_VALID && req_ready) begin
          write_d = bus.REQ_WRITE;
          inc_d   = bus.REQ_INC;
          addr_d  = bus.REQ_ADDR;
          beats_d = (bus.REQ_LEN == 9'd0) ? 9'd1 : bus.REQ_LEN;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          if (bus.REQ_WRITE) begin
            db_oe_d = 1'b1;
            db_o_d  = bus.REQ_WDATA;
          end
          phase_d = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (CE) begin
          if (phase_q == 3'd1) begin
            rdb_d   = write_q;
            wrb_d   = ~write_q;
            phase_d = STROBE_LD;
            state_d = S_STROBE;
          end else begin
            phase_d = phase_q - 3'd1;
          end
        end
      end
      S_STROBE: begin
        if (CE) begin
          if (phase_q == 3'd1) begin
            if (!write_q) begin
              rsp_rdata_d = bus.DB_I;
              rsp_valid_d = 1'b1;
            end
            rdb_d   = 1'b1;
            wrb_d   = 1'b1;
            phase_d = HOLD_LD;
            state_d = S_HOLD;
          end else begin
            phase_d = phase_q - 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (CE) begin
          if (phase_q == 3'd1) begin
            beats_d = beats_q - 9'd1;
            if (beats_q == 9'd1) begin
              csb_d   = 1'b1;
              db_oe_d = 1'b0;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              if (inc_q) addr_d = addr_q + 13'd1;
              phase_d = SETUP_LD;
              state_d = S_SETUP;
            end
          end else begin
            phase_d = phase_q - 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q     <= S_IDLE;
      phase_q     <= 3'd0;
      beats_q     <= 9'd0;
      write_q     <= 1'b0;
      inc_q       <= 1'b0;
      addr_q      <= 13'd0;
      db_o_q      <= 8'd0;
      db_oe_q     <= 1'b0;
      csb_q       <= 1'b1;
      rdb_q       <= 1'b1;
      wrb_q       <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      beats_q     <= beats_d;
      write_q     <= write_d;
      inc_q       <= inc_d;
      addr_q      <= addr_d;
      db_o_q      <= db_o_d;
      db_oe_q     <= db_oe_d;
      csb_q       <= csb_d;
      rdb_q       <= rdb_d;
      wrb_q       <= wrb_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_en_q  <= ready_en_d;
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.BUSY      = busy_q;
  assign bus.A         = addr_q;
  assign bus.DB_O      = db_o_q;
  assign bus.DB_OE     = db_oe_q;
  assign bus.RDB       = rdb_q;
  assign bus.WRB       = wrb_q;
  assign bus.CSB       = csb_q;

endmodule

// File: tb/tb_epochtv1_bus_master.sv
// Directed bench for epochtv1_bus_master with a byte-array TV-1 model.
module tb_epochtv1_bus_master;
  logic CLK = 1'b0;
  logic RESB = 1'b0;
  logic CE = 1'b0;

  epochtv1_bus_master_if bus ();

  epochtv1_bus_master dut (
    .CLK  (CLK),
    .RESB (RESB),
    .CE   (CE),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int ce_div = 1;
  int ce_ph  = 0;
  always @(negedge CLK) begin
    ce_ph = (ce_ph + 1 >= ce_div) ? 0 : ce_ph + 1;
    CE = (ce_ph == 0);
  end

  // TV-1 memory model: read data follows A, writes land on WRB rising
  logic [7:0] mem [0:8191];
  assign bus.DB_I = mem[bus.A];
  always @(posedge bus.WRB) if (RESB && !bus.CSB) mem[bus.A] = bus.DB_O;

  int compared = 0;
  int mismatched = 0;

  // bus monitor
  int busy_ticks, wrb_ticks, rdb_ticks, csb_ticks;
  int first_wrb, last_wrb, first_rdb;
  int wrb_pulses, rdb_pulses, csb_rises, rsp_cycles, rsp_pulses, oe_cycles;
  int viol;
  logic [7:0]  rsp_log [0:15];
  logic [12:0] strobe_addr [0:15];
  int strobe_n;
  logic        prev_ok = 1'b0, prev_low, prev_csb, prev_rsp = 1'b0;
  logic [12:0] prev_a;
  logic [7:0]  prev_dbo;

  always @(posedge CLK) begin
    if (!RESB) begin
      prev_ok  = 1'b0;
      prev_rsp = 1'b0;
    end else begin
      if (CE && bus.BUSY) begin
        busy_ticks++;
        if (!bus.WRB) begin
          wrb_ticks++;
          if (first_wrb == 0) first_wrb = busy_ticks;
          last_wrb = busy_ticks;
        end
        if (!bus.RDB) begin
          rdb_ticks++;
          if (first_rdb == 0) first_rdb = busy_ticks;
        end
        if (!bus.CSB) csb_ticks++;
      end
      if (bus.RSP_VALID) begin
        rsp_cycles++;
        if (!prev_rsp) begin
          if (rsp_pulses < 16) rsp_log[rsp_pulses] = bus.RSP_RDATA;
          rsp_pulses++;
        end
      end
      prev_rsp = bus.RSP_VALID;
      if (bus.DB_OE) oe_cycles++;
      if (!bus.RDB && !bus.WRB) viol++;
      if (prev_ok && (prev_low || !bus.RDB || !bus.WRB) &&
          (bus.A != prev_a || bus.DB_O != prev_dbo || bus.CSB != prev_csb)) viol++;
      prev_ok  = 1'b1;
      prev_low = !bus.RDB || !bus.WRB;
      prev_a   = bus.A;
      prev_dbo = bus.DB_O;
      prev_csb = bus.CSB;
    end
  end

  always @(negedge bus.RDB or negedge bus.WRB) begin
    if (RESB) begin
      if (!bus.RDB) rdb_pulses++;
      if (!bus.WRB) wrb_pulses++;
      if (strobe_n < 16) strobe_addr[strobe_n] = bus.A;
      strobe_n++;
    end
  end

  always @(posedge bus.CSB) if (RESB) csb_rises++;

  task automatic clear_mon();
    busy_ticks = 0; wrb_ticks = 0; rdb_ticks = 0; csb_ticks = 0;
    first_wrb = 0; last_wrb = 0; first_rdb = 0;
    wrb_pulses = 0; rdb_pulses = 0; csb_rises = 0;
    rsp_cycles = 0; rsp_pulses = 0; oe_cycles = 0; strobe_n = 0;
  endtask

  task automatic send_req(input logic w, input logic [12:0] a, input logic [7:0] d,
                          input logic [8:0] len, input logic inc);
    @(negedge CLK);
    clear_mon();
    bus.REQ_WRITE = w;
    bus.REQ_ADDR  = a;
    bus.REQ_WDATA = d;
    bus.REQ_LEN   = len;
    bus.REQ_INC   = inc;
    bus.REQ_VALID = 1'b1;
    @(posedge CLK);
    #1;
    bus.REQ_VALID = 1'b0;
    bus.REQ_ADDR  = 13'h0AAA;
    bus.REQ_WDATA = 8'hEE;
    compared++;
    if ({bus.BUSY, bus.CSB, bus.REQ_READY, bus.DB_OE, bus.A} !== {1'b1, 1'b0, 1'b0, w, a}) begin
      mismatched++;
      $display("FAIL accept: busy/csb/ready/oe/A got %b%b%b%b %h expected 10%b0 %h",
               bus.BUSY, bus.CSB, bus.REQ_READY, bus.DB_OE, bus.A, w, a);
    end
  endtask

  task automatic wait_done(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      #1;
      if (!bus.BUSY) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: BUSY still %b after %0d cycles expected 0", bus.BUSY, budget);
    end
  endtask

  task automatic test_reset();
    bus.REQ_VALID = 0; bus.REQ_WRITE = 0; bus.REQ_ADDR = 0;
    bus.REQ_WDATA = 0; bus.REQ_LEN = 0; bus.REQ_INC = 0;
    RESB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    compared++;
    if ({bus.CSB, bus.RDB, bus.WRB, bus.A, bus.DB_O, bus.DB_OE, bus.RSP_VALID,
         bus.RSP_RDATA, bus.BUSY, bus.REQ_READY} !== {3'b111, 13'h0, 8'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_state: csb/rdb/wrb %b%b%b A %h dbo %h oe %b rv %b rd %h busy %b rdy %b expected 111 0000 00 0 0 00 0 0",
               bus.CSB, bus.RDB, bus.WRB, bus.A, bus.DB_O, bus.DB_OE, bus.RSP_VALID,
               bus.RSP_RDATA, bus.BUSY, bus.REQ_READY);
    end
    @(negedge CLK);
    RESB = 1'b1;
    #1;
    compared++;
    if (bus.REQ_READY !== 1'b0) begin
      mismatched++;
      $display("FAIL ready_before_clk: got %b expected 0", bus.REQ_READY);
    end
    @(posedge CLK);
    #1;
    compared++;
    if (bus.REQ_READY !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_clk: got %b expected 1", bus.REQ_READY);
    end
  endtask

  task automatic test_single_write();
    send_req(1'b1, 13'h1005, 8'hA5, 9'd1, 1'b1);
    compared++;
    if (bus.DB_O !== 8'hA5) begin
      mismatched++;
      $display("FAIL write_dbo: got %h expected a5", bus.DB_O);
    end
    wait_done(50);
    compared++;
    if ({busy_ticks, csb_ticks, wrb_ticks, first_wrb, last_wrb, rdb_ticks} !==
        {32'd4, 32'd4, 32'd2, 32'd2, 32'd3, 32'd0}) begin
      mismatched++;
      $display("FAIL write_phases: busy %0d csb %0d wrb %0d first %0d last %0d rdb %0d expected 4 4 2 2 3 0",
               busy_ticks, csb_ticks, wrb_ticks, first_wrb, last_wrb, rdb_ticks);
    end
    compared++;
    if (mem[13'h1005] !== 8'hA5) begin
      mismatched++;
      $display("FAIL write_mem: got %h expected a5", mem[13'h1005]);
    end
    compared++;
    if ({bus.REQ_READY, bus.CSB, bus.DB_OE, bus.BUSY} !== 4'b1100) begin
      mismatched++;
      $display("FAIL write_end: rdy/csb/oe/busy got %b%b%b%b expected 1100",
               bus.REQ_READY, bus.CSB, bus.DB_OE, bus.BUSY);
    end
  endtask

  task automatic test_single_read();
    mem[13'h1203] = 8'h3C;
    send_req(1'b0, 13'h1203, 8'h77, 9'd1, 1'b1);
    wait_done(50);
    compared++;
    if ({rsp_pulses, rsp_cycles, 24'd0, rsp_log[0]} !== {32'd1, 32'd1, 32'h3C}) begin
      mismatched++;
      $display("FAIL read_rsp: pulses %0d cycles %0d data %h expected 1 1 3c",
               rsp_pulses, rsp_cycles, rsp_log[0]);
    end
    compared++;
    if ({oe_cycles, rdb_ticks, first_rdb, wrb_ticks} !== {32'd0, 32'd2, 32'd2, 32'd0}) begin
      mismatched++;
      $display("FAIL read_phases: oe %0d rdb %0d first %0d wrb %0d expected 0 2 2 0",
               oe_cycles, rdb_ticks, first_rdb, wrb_ticks);
    end
    compared++;
    if (bus.RSP_RDATA !== 8'h3C) begin
      mismatched++;
      $display("FAIL read_hold: got %h expected 3c", bus.RSP_RDATA);
    end
  endtask

  task automatic test_fill_burst();
    int bad = 0;
    for (int i = 0; i < 257; i++) mem[i] = 8'hFF;
    send_req(1'b1, 13'h0000, 8'h00, 9'd256, 1'b1);
    wait_done(2000);
    for (int i = 0; i < 256; i++) if (mem[i] !== 8'h00) bad++;
    compared++;
    if (bad !== 0) begin
      mismatched++;
      $display("FAIL fill_mem: %0d bytes not cleared expected 0", bad);
    end
    compared++;
    if (mem[256] !== 8'hFF) begin
      mismatched++;
      $display("FAIL fill_overrun: mem[100] got %h expected ff", mem[256]);
    end
    compared++;
    if ({busy_ticks, wrb_pulses, csb_rises} !== {32'd1024, 32'd256, 32'd1}) begin
      mismatched++;
      $display("FAIL fill_counts: ticks %0d wrb %0d csb_rises %0d expected 1024 256 1",
               busy_ticks, wrb_pulses, csb_rises);
    end
    compared++;
    if (bus.A !== 13'h00FF) begin
      mismatched++;
      $display("FAIL fill_last_addr: got %h expected 00ff", bus.A);
    end
  endtask

  task automatic test_wrap_fixed();
    int bad = 0;
    mem[13'h1FFF] = 8'h11;
    mem[13'h0000] = 8'h22;
    send_req(1'b0, 13'h1FFF, 8'h00, 9'd2, 1'b1);
    wait_done(100);
    compared++;
    if ({strobe_addr[0], strobe_addr[1], rsp_log[0], rsp_log[1]} !== {13'h1FFF, 13'h0000, 8'h11, 8'h22}) begin
      mismatched++;
      $display("FAIL wrap: addrs %h %h data %h %h expected 1fff 0000 11 22",
               strobe_addr[0], strobe_addr[1], rsp_log[0], rsp_log[1]);
    end
    mem[13'h1401] = 8'h00;
    send_req(1'b1, 13'h1400, 8'h5A, 9'd3, 1'b0);
    wait_done(100);
    for (int i = 0; i < 3; i++) if (strobe_addr[i] !== 13'h1400) bad++;
    compared++;
    if ({wrb_pulses, bad} !== {32'd3, 32'd0}) begin
      mismatched++;
      $display("FAIL fixed_addr: wrb %0d bad_addrs %0d expected 3 0", wrb_pulses, bad);
    end
    compared++;
    if ({mem[13'h1400], mem[13'h1401]} !== 16'h5A00) begin
      mismatched++;
      $display("FAIL fixed_mem: got %h %h expected 5a 00", mem[13'h1400], mem[13'h1401]);
    end
  endtask

  task automatic test_len_zero();
    send_req(1'b1, 13'h0010, 8'hC3, 9'd0, 1'b1);
    wait_done(50);
    compared++;
    if ({wrb_pulses, busy_ticks, 24'd0, mem[13'h0010]} !== {32'd1, 32'd4, 32'hC3}) begin
      mismatched++;
      $display("FAIL len_zero: wrb %0d ticks %0d mem %h expected 1 4 c3",
               wrb_pulses, busy_ticks, mem[13'h0010]);
    end
  endtask

  task automatic test_ce_gating();
    mem[13'h0800] = 8'hC7;
    ce_div = 3;
    send_req(1'b0, 13'h0800, 8'h00, 9'd1, 1'b1);
    wait_done(100);
    compared++;
    if ({busy_ticks, rdb_ticks, first_rdb, csb_ticks} !== {32'd4, 32'd2, 32'd2, 32'd4}) begin
      mismatched++;
      $display("FAIL ce_phases: ticks %0d rdb %0d first %0d csb %0d expected 4 2 2 4",
               busy_ticks, rdb_ticks, first_rdb, csb_ticks);
    end
    compared++;
    if ({rsp_pulses, rsp_cycles, 24'd0, rsp_log[0]} !== {32'd1, 32'd1, 32'hC7}) begin
      mismatched++;
      $display("FAIL ce_rsp: pulses %0d cycles %0d data %h expected 1 1 c7",
               rsp_pulses, rsp_cycles, rsp_log[0]);
    end
    ce_div = 1;
  endtask

  task automatic test_reset_mid_burst();
    bit hit = 0;
    send_req(1'b0, 13'h0100, 8'h00, 9'd4, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK);
      #1;
      if (rdb_pulses == 2 && !bus.RDB) begin
        hit = 1;
        break;
      end
    end
    compared++;
    if (hit !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_strobe_reach: got %b expected 1", hit);
    end
    RESB = 1'b0;
    #1;
    compared++;
    if ({bus.CSB, bus.RDB, bus.WRB, bus.DB_OE, bus.BUSY} !== 5'b11100) begin
      mismatched++;
      $display("FAIL mid_reset: csb/rdb/wrb/oe/busy got %b%b%b%b%b expected 11100",
               bus.CSB, bus.RDB, bus.WRB, bus.DB_OE, bus.BUSY);
    end
    @(negedge CLK);
    RESB = 1'b1;
    clear_mon();
    repeat (20) @(posedge CLK);
    #1;
    compared++;
    if ({bus.REQ_READY, bus.BUSY, bus.CSB, rsp_pulses, rdb_pulses} !== {3'b101, 32'd0, 32'd0}) begin
      mismatched++;
      $display("FAIL after_reset: rdy/busy/csb %b%b%b rsp %0d rdb %0d expected 101 0 0",
               bus.REQ_READY, bus.BUSY, bus.CSB, rsp_pulses, rdb_pulses);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    viol = 0;
    clear_mon();
    test_reset();
    test_single_write();
    test_single_read();
    test_fill_burst();
    test_wrap_fixed();
    test_len_zero();
    test_ce_gating();
    test_reset_mid_burst();
    compared++;
    if (viol !== 0) begin
      mismatched++;
      $display("FAIL strobe_order: %0d violations expected 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
